// File: rtl/fsm_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// width helpers used by the arbiter top and its rotate-priority picker.
package fsm_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Combinational rotate-priority select: first set request bit at or above
// i_ptr, wrapping to 0, reported as an index.
module rr_pick
    import fsm_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = idx_w(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_any,
    output logic [ID_W-1:0] o_idx
);

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N);

    logic [N-1:0]    w_rot;
    logic [ID_W-1:0] w_off;
    logic [ID_W:0]   w_sum;

    // Rotate so that bit 0 of w_rot corresponds to requester i_ptr.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_any = 1'b0;
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_any = 1'b1;
                w_off = ID_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = ID_W'((w_sum >= N_EXT) ? (w_sum - N_EXT) : w_sum);

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter that hands one shared FSM datapath to N requesters,
// with a hold limit per grant and a one-cycle gap between grant windows.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate among req from r_ptr (code 11 -> IDLE)
//   ST_GRANT | one requester owns the mux; hold counter running
//   ST_GAP   | single dead cycle after a release before re-arbitration
module fsm_rr_arbiter
    import fsm_pkg::*;
#(
    parameter int N        = 2,
    parameter int ID_W     = idx_w(N),
    parameter int MAX_HOLD = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_done,
    output logic [N-1:0]    o_gnt,
    output logic            o_gnt_valid,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_timeout,
    output logic [ST_W-1:0] o_state
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t            r_state;
    logic [N-1:0]      r_gnt;
    logic              r_gnt_valid;
    logic [ID_W-1:0]   r_gnt_id;
    logic              r_timeout;
    logic [ID_W-1:0]   r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    state_t            w_state_nxt;
    logic [N-1:0]      w_gnt_nxt;
    logic [ID_W-1:0]   w_gnt_id_nxt;
    logic              w_timeout_nxt;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic              w_pick_any;
    logic [ID_W-1:0]   w_pick_idx;
    logic              w_own_done;
    logic              w_own_req;
    logic              w_at_limit;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    assign w_own_done = i_done[r_gnt_id];
    assign w_own_req  = i_req[r_gnt_id];
    assign w_at_limit = (r_hold_cnt == HOLD_W'(MAX_HOLD));

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;

        case (r_state)
            ST_GRANT: begin
                if (w_own_done || !w_own_req || w_at_limit) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_hold_nxt    = '0;
                    // A coincident done or request drop is a normal release.
                    w_timeout_nxt = w_at_limit && !w_own_done && w_own_req;
                    w_ptr_nxt     = (r_gnt_id == ID_W'(N - 1)) ? '0
                                                              : r_gnt_id + ID_W'(1);
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                w_state_nxt  = ST_IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
            end
            default: begin
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_hold_nxt   = '0;
                w_state_nxt  = ST_IDLE;
                if (w_pick_any) begin
                    w_state_nxt             = ST_GRANT;
                    w_gnt_nxt[w_pick_idx]   = 1'b1;
                    w_gnt_id_nxt            = w_pick_idx;
                    w_hold_nxt              = HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_timeout   <= 1'b0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt_id    = r_gnt_id;
    assign o_timeout   = r_timeout;
    assign o_state     = r_state;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter: a vector table for basic arbitration
// plus hand-written sequences for hold limit, reset mid-grant and N=3.
module tb_fsm_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic [0:0] gnt_id;
    logic       timeout;
    logic [1:0] state;

    logic       reset3;
    logic [2:0] req3;
    logic [2:0] done3;
    logic [2:0] gnt3;
    logic       gnt_valid3;
    logic [1:0] gnt_id3;
    logic       timeout3;
    logic [1:0] state3;

    int n_checks = 0;
    int n_errors = 0;

    fsm_rr_arbiter #(.N(2), .ID_W(1), .MAX_HOLD(8)) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_done      (done),
        .o_gnt       (gnt),
        .o_gnt_valid (gnt_valid),
        .o_gnt_id    (gnt_id),
        .o_timeout   (timeout),
        .o_state     (state)
    );

    fsm_rr_arbiter #(.N(3), .ID_W(2), .MAX_HOLD(8)) u_dut3 (
        .i_clk       (clk),
        .i_reset     (reset3),
        .i_req       (req3),
        .i_done      (done3),
        .o_gnt       (gnt3),
        .o_gnt_valid (gnt_valid3),
        .o_gnt_id    (gnt_id3),
        .o_timeout   (timeout3),
        .o_state     (state3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] gnt;
        logic [1:0] st;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] dn,
                       input logic [1:0] g, input logic [1:0] s, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.done = dn; v.gnt = g; v.st = s; v.to = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string tag, input logic [1:0] eg, input logic [1:0] es,
                          input logic et);
        chk({tag, ".gnt"},   32'(gnt),       32'(eg));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(|eg));
        chk({tag, ".id"},    32'(gnt_id),    (eg == 2'b10) ? 32'd1 : 32'd0);
        chk({tag, ".state"}, 32'(state),     32'(es));
        chk({tag, ".to"},    32'(timeout),   32'(et));
    endtask

    task automatic check3(input string tag, input logic [2:0] eg, input logic [1:0] es);
        logic [1:0] eid;
        eid = (eg == 3'b100) ? 2'd2 : (eg == 3'b010) ? 2'd1 : 2'd0;
        chk({tag, ".gnt3"},   32'(gnt3),       32'(eg));
        chk({tag, ".id3"},    32'(gnt_id3),    32'(eid));
        chk({tag, ".valid3"}, 32'(gnt_valid3), 32'(|eg));
        chk({tag, ".state3"}, 32'(state3),     32'(es));
        chk({tag, ".to3"},    32'(timeout3),   32'd0);
    endtask

    initial begin
        reset  = 1'b1; req  = 2'b11; done  = 2'b00;
        reset3 = 1'b1; req3 = 3'b000; done3 = 3'b000;

        //   rst  req    done   gnt    state  to
        add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0);
        add(1'b0, 2'b11, 2'b01, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b11, 2'b01, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0);
        add(1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0);
        add(1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0);
        add(1'b0, 2'b01, 2'b01, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b11, 2'b10, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            reset = vecs[k].rst;
            req   = vecs[k].req;
            done  = vecs[k].done;
            tick();
            check2($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].st, vecs[k].to);
        end
        done = 2'b00;

        // Continuous req=11: MAX_HOLD windows alternating, timeout after each.
        req = 2'b11;
        for (int w = 0; w < 3; w++) begin
            logic [1:0] eg;
            eg = (w % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check2($sformatf("hold%0d.c1", w), eg, 2'b01, 1'b0);
            for (int c = 2; c <= 8; c++) begin
                tick();
                check2($sformatf("hold%0d.c%0d", w, c), eg, 2'b01, 1'b0);
            end
            tick();
            check2($sformatf("hold%0d.rel", w), 2'b00, 2'b10, 1'b1);
            tick();
            check2($sformatf("hold%0d.gap", w), 2'b00, 2'b00, 1'b0);
        end

        // done coinciding with the hold limit: release without timeout.
        req = 2'b01;
        tick();
        check2("lim.c1", 2'b01, 2'b01, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            tick();
            check2($sformatf("lim.c%0d", c), 2'b01, 2'b01, 1'b0);
        end
        done = 2'b01;
        tick();
        check2("lim.rel", 2'b00, 2'b10, 1'b0);
        done = 2'b00;
        tick();
        check2("lim.gap", 2'b00, 2'b00, 1'b0);

        // Reset mid-grant drops gnt at that edge and clears the pointer.
        req = 2'b11;
        tick();
        check2("rst.g1", 2'b10, 2'b01, 1'b0);
        tick();
        check2("rst.g2", 2'b10, 2'b01, 1'b0);
        reset = 1'b1;
        tick();
        check2("rst.in", 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        tick();
        check2("rst.after", 2'b01, 2'b01, 1'b0);
        done = 2'b01;
        tick();
        check2("rst.rel", 2'b00, 2'b10, 1'b0);
        done = 2'b00;
        req  = 2'b00;

        // N=3: move pointer to 1, then req=101 must go to 2 before 0.
        reset3 = 1'b0;
        req3   = 3'b001;
        tick();
        check3("n3.a", 3'b001, 2'b01);
        done3 = 3'b001;
        tick();
        check3("n3.rel_a", 3'b000, 2'b10);
        done3 = 3'b000;
        req3  = 3'b101;
        tick();
        check3("n3.gap_a", 3'b000, 2'b00);
        tick();
        check3("n3.b", 3'b100, 2'b01);
        done3 = 3'b100;
        tick();
        check3("n3.rel_b", 3'b000, 2'b10);
        done3 = 3'b000;
        tick();
        check3("n3.gap_b", 3'b000, 2'b00);
        tick();
        check3("n3.c", 3'b001, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
